// File: rtl/minv_reg_seq.sv
// minv_reg_seq: sequencer for the MINV_REG_X2 slice chain (word load/unload, N-bit SHR, clear).
// Optional abort input when MINV_REG_SEQ_ABORT_EN is defined. Ports: cmd/in/out handshakes, reg_* slice controls, busy/done.
module minv_reg_seq #(
  parameter int NWORDS = 8,
  parameter int CNTW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MINV_REG_SEQ_ABORT_EN
  input  logic            abort,
`endif
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [CNTW-1:0] cmd_cnt,
  input  logic            cmd_fill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  input  logic [31:0]     reg_rdata,
  output logic [31:0]     reg_wdata,
  output logic            reg_we,
  output logic            reg_sel_cyc,
  output logic            reg_sel_rs,
  output logic            reg_bit256,
  output logic            reg_clr,
  output logic            busy,
  output logic            done
);

  localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_UNLD = 3'd2;
  localparam logic [2:0] S_SHR  = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [CNTW-1:0] scnt_q, scnt_d;
  logic            fill_q, fill_d;
  logic            wlast;

  assign wlast = (wcnt_q == WCW'(NWORDS - 1));
  assign busy  = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    scnt_d      = scnt_q;
    fill_d      = fill_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    reg_wdata   = '0;
    reg_we      = 1'b0;
    reg_sel_cyc = 1'b0;
    reg_sel_rs  = 1'b0;
    reg_bit256  = 1'b0;
    reg_clr     = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          scnt_d = cmd_cnt;
          fill_d = cmd_fill;
          wcnt_d = '0;
          unique case (cmd_op)
            2'd0:    state_d = S_LOAD;
            2'd1:    state_d = S_UNLD;
            2'd2:    state_d = S_SHR;
            default: state_d = S_CLR;
          endcase
        end
      end
      S_LOAD: begin
        in_ready  = 1'b1;
        reg_we    = in_valid;
        reg_wdata = in_data;
        if (in_valid) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (wlast) state_d = S_DONE;
        end
      end
      S_UNLD: begin
        // rotation writes regout back into the top slice
        out_valid   = 1'b1;
        out_data    = reg_rdata;
        reg_we      = out_ready;
        reg_sel_cyc = out_ready;
        if (out_ready) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (wlast) state_d = S_DONE;
        end
      end
      S_SHR: begin
        if (scnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          reg_we     = 1'b1;
          reg_sel_rs = 1'b1;
          reg_bit256 = fill_q;
          scnt_d     = scnt_q - CNTW'(1);
          if (scnt_q == CNTW'(1)) state_d = S_DONE;
        end
      end
      S_CLR: begin
        reg_clr = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        wcnt_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MINV_REG_SEQ_ABORT_EN
    // abort squashes every slice control of this cycle
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      wcnt_d      = '0;
      scnt_d      = '0;
      fill_d      = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      reg_wdata   = '0;
      reg_we      = 1'b0;
      reg_sel_cyc = 1'b0;
      reg_sel_rs  = 1'b0;
      reg_bit256  = 1'b0;
      reg_clr     = 1'b0;
      done        = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_minv_reg_seq.sv
// tb_minv_reg_seq: bench for minv_reg_seq with a behavioural 256-bit chain
// and an arithmetic reference of the expected chain contents.
`timescale 1ns/1ps
module tb_minv_reg_seq;
  localparam int NW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [CW-1:0] cmd_cnt = '0;
  logic          cmd_fill = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [31:0]   reg_rdata;
  logic [31:0]   reg_wdata;
  logic          reg_we, reg_sel_cyc, reg_sel_rs;
  logic          reg_bit256, reg_clr, busy, done;
`ifdef MINV_REG_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [255:0] chain = '0;
  logic [255:0] expv  = '0;
  logic [31:0]  wbuf [NW];
  logic [31:0]  got  [NW];
  int n_we = 0, n_rs = 0, n_cyc = 0, n_clr = 0, n_done = 0;

  always #5 clk = ~clk;

  minv_reg_seq #(.NWORDS(NW), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MINV_REG_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .reg_rdata(reg_rdata), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_sel_cyc(reg_sel_cyc), .reg_sel_rs(reg_sel_rs),
    .reg_bit256(reg_bit256), .reg_clr(reg_clr),
    .busy(busy), .done(done)
  );

  // behavioural slice chain: slice 0 is the lowest word
  assign reg_rdata = chain[31:0];
  always @(posedge clk) begin
    if (reg_clr) chain <= '0;
    else if (reg_we) begin
      if (reg_sel_rs) chain <= {reg_bit256, chain[255:1]};
      else if (reg_sel_cyc) chain <= {chain[31:0], chain[255:32]};
      else chain <= {reg_wdata, chain[255:32]};
    end
    n_we   <= n_we + int'(reg_we);
    n_rs   <= n_rs + int'(reg_we && reg_sel_rs);
    n_cyc  <= n_cyc + int'(reg_we && reg_sel_cyc);
    n_clr  <= n_clr + int'(reg_clr);
    n_done <= n_done + int'(done);
  end

  task automatic chkb(input string tag, input logic o, input logic e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chkv(input string tag, input logic [255:0] o, input logic [255:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [255:0] pack_words();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = wbuf[i];
    return v;
  endfunction

  function automatic logic [255:0] shr_model(input logic [255:0] v, input int n, input logic f);
    logic [255:0] ones;
    ones = '1;
    return (v >> n) | (f ? ~(ones >> n) : '0);
  endfunction

  task automatic idle_outs(input string tag);
    chkb({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_done"}, done, 1'b0);
    chkb({tag, "_in_ready"}, in_ready, 1'b0);
    chkb({tag, "_out_valid"}, out_valid, 1'b0);
    chkb({tag, "_we"}, reg_we, 1'b0);
    chkb({tag, "_clr"}, reg_clr, 1'b0);
    chkw({tag, "_wdata"}, reg_wdata, 32'h0);
  endtask

  // called at a negedge in IDLE; returns at the first negedge after accept
  task automatic issue(input logic [1:0] op, input int cnt, input logic f);
    int w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = CW'(cnt);
    cmd_fill  = f;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chkb("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic feed(input int nwords, input int gap_pct, output int t);
    int k;
    logic acc;
    k = 0;
    t = 0;
    while (k < nwords && t < 400) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? wbuf[k] : $urandom;
      #1;
      acc = in_valid && in_ready;
      @(negedge clk);
      t++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_load(input int gap_pct);
    int t, we0, d0;
    we0 = n_we;
    d0  = n_done;
    issue(2'd0, 0, 1'b0);
    feed(NW, gap_pct, t);
    chkb("load_done", done, 1'b1);
    if (gap_pct == 0) chki("load_cycles", t, NW);
    @(negedge clk);
    chki("load_we", n_we - we0, NW);
    chki("load_done_cnt", n_done - d0, 1);
    expv = pack_words();
    chkv("load_val", chain, expv);
  endtask

  task automatic run_unld(input bit rnd);
    int k, t, c0;
    logic [31:0] prev;
    logic stall;
    c0 = n_cyc;
    k = 0;
    t = 0;
    stall = 1'b0;
    prev = '0;
    issue(2'd1, 0, 1'b0);
    while (k < NW && t < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((t % 2) == 0);
      #1;
      chkb("unld_valid", out_valid, 1'b1);
      if (stall) chkw("unld_stable", out_data, prev);
      if (out_ready) begin
        got[k] = out_data;
        k++;
      end
      prev  = out_data;
      stall = !out_ready;
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    chkb("unld_done", done, 1'b1);
    for (int i = 0; i < NW; i++) chkw("unld_word", got[i], expv[32*i +: 32]);
    @(negedge clk);
    chki("unld_rot", n_cyc - c0, NW);
    chkv("unld_keep", chain, expv);
  endtask

  task automatic run_shr(input int n, input logic f);
    int k, we0, rs0, d0;
    we0 = n_we;
    rs0 = n_rs;
    d0  = n_done;
    issue(2'd2, n, f);
    wait_done(k);
    chki("shr_lat", k, (n == 0) ? 2 : n + 1);
    chkb("shr_busy_done", cmd_ready, 1'b0);
    @(negedge clk);
    chki("shr_we", n_we - we0, n);
    chki("shr_rs", n_rs - rs0, n);
    chki("shr_done_cnt", n_done - d0, 1);
    chkb("shr_idle", cmd_ready, 1'b1);
    expv = shr_model(expv, n, f);
    chkv("shr_val", chain, expv);
  endtask

  task automatic run_clr();
    int k, c0, we0;
    c0  = n_clr;
    we0 = n_we;
    issue(2'd3, 0, 1'b0);
    chkb("clr_pulse", reg_clr, 1'b1);
    wait_done(k);
    chki("clr_lat", k, 2);
    @(negedge clk);
    chki("clr_cnt", n_clr - c0, 1);
    chki("clr_we", n_we - we0, 0);
    expv = '0;
    chkv("clr_val", chain, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0;
    #3;
    idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed: load 0x11111111..0x88888888 back-to-back
    for (int i = 0; i < NW; i++) wbuf[i] = 32'h11111111 * (i + 1);
    run_load(0);
    chkw("load_low_slice", reg_rdata, 32'h11111111);

    // directed: unload with out_ready 1010..
    run_unld(1'b0);

    // directed: shift 256'h1 right by 3 with fill 1
    for (int i = 0; i < NW; i++) wbuf[i] = (i == 0) ? 32'h1 : 32'h0;
    run_load(0);
    run_shr(3, 1'b1);
    chkv("shr3_const", chain, {3'b111, 253'b0});

    // directed: zero-count shift and clear
    run_shr(0, 1'b1);
    run_clr();

    // directed: reset in the middle of a load
    for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
    d0 = n_done;
    issue(2'd0, 0, 1'b0);
    feed(4, 0, t);
    #2;
    rst_n = 1'b0;
    #1;
    idle_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chki("midrst_no_done", n_done - d0, 0);
    for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
    run_load(0);

`ifdef MINV_REG_SEQ_ABORT_EN
    begin
      int rs0;
      d0  = n_done;
      rs0 = n_rs;
      issue(2'd2, 10, 1'b1);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      #1;
      chkb("abort_we", reg_we, 1'b0);
      chkb("abort_clr", reg_clr, 1'b0);
      @(negedge clk);
      abort = 1'b0;
      chkb("abort_ready", cmd_ready, 1'b1);
      chkb("abort_done", done, 1'b0);
      chki("abort_shifts", n_rs - rs0, 2);
      chki("abort_no_done", n_done - d0, 0);
      expv = shr_model(expv, 2, 1'b1);
      chkv("abort_val", chain, expv);
    end
`endif

    // randomized mix
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
      run_load(30);
      run_unld(1'b1);
      run_shr($urandom_range(0, 60), 1'($urandom_range(0, 1)));
      run_unld(1'b1);
      if (it % 3 == 2) run_clr();
    end
    run_shr(255, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
